// File: rtl/nabp_pkg.sv
// nabp_pkg: shared widths, fixed-point accumulator types and scheduler state encoding
// for the projection-line mapper datapath.
package nabp_pkg;
    localparam int kAngleLength   = 9;
    localparam int kPartWidth     = 3;
    localparam int kAccuInitWidth = 24;
    localparam int kAccuBaseWidth = 20;

    typedef logic signed [kAccuInitWidth-1:0] tMapAccuInit;
    typedef logic signed [kAccuBaseWidth-1:0] tMapAccuBase;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_KICK, S_RUN, S_DONE} sched_state_e;

    function automatic tMapAccuInit widen_base(input tMapAccuBase b);
        return tMapAccuInit'(b);
    endfunction
endpackage

// File: rtl/nabp_map_sched_counter.sv
// nabp_map_sched_counter: nested partition/angle counter; partition is the inner digit,
// both wrap to zero after the final pass so the next frame starts clean.
module nabp_map_sched_counter
    import nabp_pkg::*;
#(
    parameter int kNoOfAngles = 180,
    parameter int kNoOfParts  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear_i,
    input  logic                    step_i,
    output logic [kAngleLength-1:0] angle_o,
    output logic [kPartWidth-1:0]   part_o,
    output logic                    last_part_o,
    output logic                    last_angle_o
);
    logic [kAngleLength-1:0] angle_q, angle_d;
    logic [kPartWidth-1:0]   part_q, part_d;

    assign last_part_o  = part_q == kPartWidth'(kNoOfParts - 1);
    assign last_angle_o = angle_q == kAngleLength'(kNoOfAngles - 1);
    assign angle_o      = angle_q;
    assign part_o       = part_q;

    always_comb begin
        part_d  = clear_i ? '0 : !step_i ? part_q : last_part_o ? '0 : part_q + kPartWidth'(1);
        angle_d = clear_i ? '0 : !(step_i && last_part_o) ? angle_q :
                  last_angle_o ? '0 : angle_q + kAngleLength'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            angle_q <= '0;
            part_q  <= '0;
        end else begin
            angle_q <= angle_d;
            part_q  <= part_d;
        end
    end
endmodule

// File: rtl/nabp_map_scheduler.sv
// nabp_map_scheduler: walks every (angle, partition) pass of one frame, loading mapper
// accumulator constants from the angle table and handshaking each pass with the shifter.
module nabp_map_scheduler
    import nabp_pkg::*;
#(
    parameter int kNoOfAngles = 180,
    parameter int kNoOfParts  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sc_start,
    input  logic                      sc_abort,
    output logic                      sc_busy,
    output logic                      sc_done,
    output logic                      lut_req,
    output logic [kAngleLength-1:0]   lut_angle,
    input  logic [kAccuInitWidth-1:0] lut_init,
    input  logic [kAccuBaseWidth-1:0] lut_base,
    input  logic [kAccuBaseWidth-1:0] lut_step,
    output logic [kAccuInitWidth-1:0] mp_accu_init,
    output logic [kAccuBaseWidth-1:0] mp_accu_base,
    output logic                      sh_kick,
    input  logic                      sh_ack,
    input  logic                      sh_done,
    output logic [kAngleLength-1:0]   cur_angle,
    output logic [kPartWidth-1:0]     cur_part
);
    sched_state_e state_q;
    logic         sc_busy_q, sc_done_q, lut_req_q, sh_kick_q;
    tMapAccuInit  accu_init_q;
    tMapAccuBase  accu_base_q, step_q;
    logic         last_part, last_angle, cnt_clear, cnt_step;

    // Abort outranks a coincident sh_done, so the counter must not advance on it.
    assign cnt_clear = (state_q == S_IDLE) ? sc_start : sc_abort;
    assign cnt_step  = state_q == S_RUN && sh_done && !sc_abort;

    nabp_map_sched_counter #(
        .kNoOfAngles(kNoOfAngles),
        .kNoOfParts (kNoOfParts)
    ) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (cnt_clear),
        .step_i      (cnt_step),
        .angle_o     (cur_angle),
        .part_o      (cur_part),
        .last_part_o (last_part),
        .last_angle_o(last_angle)
    );

    assign lut_angle    = cur_angle;
    assign sc_busy      = sc_busy_q;
    assign sc_done      = sc_done_q;
    assign lut_req      = lut_req_q;
    assign sh_kick      = sh_kick_q;
    assign mp_accu_init = accu_init_q;
    assign mp_accu_base = accu_base_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sc_busy_q   <= 1'b0;
            sc_done_q   <= 1'b0;
            lut_req_q   <= 1'b0;
            sh_kick_q   <= 1'b0;
            accu_init_q <= '0;
            accu_base_q <= '0;
            step_q      <= '0;
        end else begin
            sc_done_q <= 1'b0;
            lut_req_q <= 1'b0;
            case (state_q)
                S_IDLE: if (sc_start) begin
                    state_q   <= S_FETCH;
                    sc_busy_q <= 1'b1;
                    lut_req_q <= 1'b1;
                end
                S_FETCH: state_q <= S_LOAD;
                // Table data is valid only in this cycle, one cycle after lut_req.
                S_LOAD: begin
                    state_q     <= S_KICK;
                    sh_kick_q   <= 1'b1;
                    accu_init_q <= lut_init;
                    accu_base_q <= lut_base;
                    step_q      <= lut_step;
                end
                S_KICK: if (sh_ack) begin
                    state_q   <= S_RUN;
                    sh_kick_q <= 1'b0;
                end
                S_RUN: if (sh_done) begin
                    if (!last_part) begin
                        state_q     <= S_KICK;
                        sh_kick_q   <= 1'b1;
                        accu_init_q <= accu_init_q + widen_base(step_q);
                    end else if (!last_angle) begin
                        state_q   <= S_FETCH;
                        lut_req_q <= 1'b1;
                    end else begin
                        state_q   <= S_DONE;
                        sc_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    sc_busy_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
            if (sc_abort && state_q != S_IDLE) begin
                state_q   <= S_IDLE;
                sc_busy_q <= 1'b0;
                sc_done_q <= 1'b0;
                lut_req_q <= 1'b0;
                sh_kick_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nabp_map_scheduler.sv
// tb_nabp_map_scheduler: two scheduler instances (180x4 and 2x1) driven by a negedge
// angle-table and mapper model, with frame-level vectors plus abort/reset sequences.
module tb_nabp_map_scheduler;
    import nabp_pkg::*;

    typedef struct {
        int k;
        int ack;
        int dn;
        int kicks;
        int fetches;
        int len;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic sc_start[2], sc_abort[2], sh_ack[2], sh_done[2];
    logic sc_busy[2], sc_done[2], lut_req[2], sh_kick[2];
    logic [kAngleLength-1:0]   lut_angle[2], cur_angle[2];
    logic [kPartWidth-1:0]     cur_part[2];
    logic [kAccuInitWidth-1:0] lut_init[2], mp_accu_init[2];
    logic [kAccuBaseWidth-1:0] lut_base[2], lut_step[2], mp_accu_base[2];

    int n_chk = 0, n_fail = 0, cyc_n = 0, t0 = 0;
    int ea[2], ep[2], kicks[2], fetches[2], dones[2], kc[2], rc[2], ack_dly[2], done_dly[2];
    bit kick_d[2], lreq_d[2], run[2], inj_done[2];
    logic [kAngleLength-1:0] la_d[2];
    logic [23:0] first_init[2][4];
    logic [43:0] cap[2];
    vec_t vecs[4];
    logic [23:0] exp4[4];
    int vk, len, n, saved;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        nabp_map_scheduler #(
            .kNoOfAngles(g == 0 ? 180 : 2),
            .kNoOfParts (g == 0 ? 4 : 1)
        ) dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .sc_start    (sc_start[g]),
            .sc_abort    (sc_abort[g]),
            .sc_busy     (sc_busy[g]),
            .sc_done     (sc_done[g]),
            .lut_req     (lut_req[g]),
            .lut_angle   (lut_angle[g]),
            .lut_init    (lut_init[g]),
            .lut_base    (lut_base[g]),
            .lut_step    (lut_step[g]),
            .mp_accu_init(mp_accu_init[g]),
            .mp_accu_base(mp_accu_base[g]),
            .sh_kick     (sh_kick[g]),
            .sh_ack      (sh_ack[g]),
            .sh_done     (sh_done[g]),
            .cur_angle   (cur_angle[g]),
            .cur_part    (cur_part[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Instance 0 table: init = 0x1000 + a*0x1000, base = 0x80 + a, step = -256.
    // Instance 1 table: init = 0x100*(a+1), base = 0x80 << a, step = 0x40 (never applied).
    function automatic logic [43:0] exp_mp(input int k, input int a, input int p);
        logic [23:0] i;
        logic [19:0] b;
        if (k == 0) begin
            i = 24'h001000 + 24'(a << 12) - 24'(p * 256);
            b = 20'h00080 + 20'(a);
        end else begin
            i = 24'(256 * (a + 1));
            b = 20'(128 << a);
        end
        return {i, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int k);
        ea[k] = 0; ep[k] = 0; kicks[k] = 0; fetches[k] = 0; dones[k] = 0;
        sc_start[k] = 1'b1;
        tick();
        t0 = cyc_n;
        sc_start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, output int l);
        int c = 0;
        while (sc_busy[k] && c < 20000) begin
            tick();
            c++;
        end
        chk("idle_timeout", sc_busy[k], 0);
        l = cyc_n - t0;
    endtask

    task automatic zero_outs(input int k);
        chk("zero_mp", {mp_accu_init[k], mp_accu_base[k]}, 0);
        chk("zero_ctl", {sc_busy[k], sc_done[k], lut_req[k], sh_kick[k], lut_angle[k],
                         cur_angle[k], cur_part[k]}, 0);
    endtask

    // Monitor first (outputs are stable at negedge), then table and mapper models.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sh_kick[k] && !kick_d[k]) begin
                chk("kick_angle", cur_angle[k], ea[k]);
                chk("kick_part", cur_part[k], ep[k]);
                chk("kick_accu", {mp_accu_init[k], mp_accu_base[k]}, exp_mp(k, ea[k], ep[k]));
                if (kicks[k] < 4) first_init[k][kicks[k]] = mp_accu_init[k];
                cap[k] = {mp_accu_init[k], mp_accu_base[k]};
                kicks[k]++;
                ep[k]++;
                if (ep[k] == (k == 0 ? 4 : 1)) begin
                    ep[k] = 0;
                    ea[k]++;
                end
            end
            kick_d[k] = sh_kick[k];
            if (lut_req[k]) begin
                fetches[k]++;
                chk("fetch_angle", lut_angle[k], ea[k]);
            end
            if (sc_done[k]) dones[k]++;
            {lut_init[k], lut_base[k]} = lreq_d[k] ? exp_mp(k, int'(la_d[k]), 0) :
                                         {24'($urandom), 20'($urandom)};
            lut_step[k] = lreq_d[k] ? (k == 0 ? 20'hFFF00 : 20'h00040) : 20'($urandom);
            lreq_d[k] = lut_req[k];
            la_d[k] = lut_angle[k];
            sh_ack[k] = 1'b0;
            sh_done[k] = 1'b0;
            if (!sc_busy[k]) begin
                run[k] = 1'b0;
                kc[k] = 0;
            end else if (run[k]) begin
                if (rc[k] == done_dly[k]) begin
                    sh_done[k] = 1'b1;
                    run[k] = 1'b0;
                    chk("accu_stable", {mp_accu_init[k], mp_accu_base[k]}, cap[k]);
                end else rc[k]++;
            end else if (sh_kick[k]) begin
                if (kc[k] == ack_dly[k]) begin
                    sh_ack[k] = 1'b1;
                    run[k] = 1'b1;
                    rc[k] = 0;
                    kc[k] = 0;
                end else kc[k]++;
            end
            if (inj_done[k]) begin
                sh_done[k] = 1'b1;
                inj_done[k] = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Frame length = angles*(2 + parts*(ack+done+2)) + 1 cycles, start edge to idle edge.
        vecs[0] = '{k: 1, ack: 2, dn: 10, kicks: 2,   fetches: 2,   len: 33};
        vecs[1] = '{k: 0, ack: 1, dn: 1,  kicks: 720, fetches: 180, len: 3241};
        vecs[2] = '{k: 0, ack: 0, dn: 0,  kicks: 720, fetches: 180, len: 1801};
        vecs[3] = '{k: 1, ack: 0, dn: 3,  kicks: 2,   fetches: 2,   len: 15};
        exp4 = '{24'h001000, 24'h000F00, 24'h000E00, 24'h000D00};
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sc_start[k] = 0; sc_abort[k] = 0; sh_ack[k] = 0; sh_done[k] = 0;
            lut_init[k] = 0; lut_base[k] = 0; lut_step[k] = 0;
            ea[k] = 0; ep[k] = 0; kicks[k] = 0; fetches[k] = 0; dones[k] = 0;
            kc[k] = 0; rc[k] = 0; ack_dly[k] = 0; done_dly[k] = 0;
            kick_d[k] = 0; lreq_d[k] = 0; run[k] = 0; inj_done[k] = 0; la_d[k] = 0;
        end
        repeat (3) tick();
        zero_outs(0);
        zero_outs(1);
        reset_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            vk = vecs[i].k;
            ack_dly[vk] = vecs[i].ack;
            done_dly[vk] = vecs[i].dn;
            start(vk);
            wait_idle(vk, len);
            chk("frame_kicks", kicks[vk], vecs[i].kicks);
            chk("frame_fetches", fetches[vk], vecs[i].fetches);
            chk("frame_dones", dones[vk], 1);
            chk("frame_len", len, vecs[i].len);
            chk("frame_kick_low", sh_kick[vk], 0);
            if (i == 0) begin
                chk("p1_init0", first_init[1][0], 24'h000100);
                chk("p1_init1", first_init[1][1], 24'h000200);
            end
            if (i == 1)
                for (int j = 0; j < 4; j++) chk("p4_init_seq", first_init[0][j], exp4[j]);
            repeat (2) tick();
        end

        // Abort in RUN of angle 5 partition 2, coinciding with sh_done.
        ack_dly[0] = 0;
        done_dly[0] = 4;
        start(0);
        n = 0;
        while (!(cur_angle[0] == 5 && cur_part[0] == 2 && !sh_kick[0] && sc_busy[0]) && n < 2000) begin
            tick();
            n++;
        end
        chk("abort_reach_run", n < 2000, 1);
        sc_abort[0] = 1'b1;
        inj_done[0] = 1'b1;
        tick();
        sc_abort[0] = 1'b0;
        chk("abort_ctl", {sc_busy[0], sh_kick[0], lut_req[0], sc_done[0]}, 0);
        chk("abort_cnt", {cur_angle[0], cur_part[0]}, 0);
        repeat (5) tick();
        chk("abort_no_done", dones[0], 0);
        chk("abort_idle_kick", sh_kick[0], 0);
        start(0);
        chk("restart_fetch", {lut_req[0], lut_angle[0]}, {1'b1, 9'd0});
        sc_abort[0] = 1'b1;
        tick();
        sc_abort[0] = 1'b0;
        chk("abort_fetch", {sc_busy[0], lut_req[0]}, 0);
        tick();
        ea[0] = 0; ep[0] = 0;
        sc_start[0] = 1'b1;
        sc_abort[0] = 1'b1;
        tick();
        sc_start[0] = 1'b0;
        sc_abort[0] = 1'b0;
        chk("start_beats_abort", {sc_busy[0], lut_req[0]}, 2'b11);
        sc_abort[0] = 1'b1;
        tick();
        sc_abort[0] = 1'b0;
        tick();

        // sh_done in KICK and sc_start while busy are both ignored.
        ack_dly[1] = 2;
        done_dly[1] = 10;
        start(1);
        n = 0;
        while (!sh_kick[1] && n < 50) begin
            tick();
            n++;
        end
        inj_done[1] = 1'b1;
        repeat (2) tick();
        sc_start[1] = 1'b1;
        tick();
        sc_start[1] = 1'b0;
        wait_idle(1, len);
        chk("ign_kicks", kicks[1], 2);
        chk("ign_dones", dones[1], 1);
        chk("ign_len", len, 33);
        repeat (2) tick();

        // Asynchronous reset between clock edges mid-frame.
        ack_dly[0] = 1;
        done_dly[0] = 1;
        start(0);
        repeat (30) tick();
        #2;
        reset_n = 1'b0;
        #1;
        zero_outs(0);
        zero_outs(1);
        saved = kicks[0];
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_ctl", {sc_busy[0], sh_kick[0], lut_req[0], sc_done[0]}, 0);
        chk("post_rst_kicks", kicks[0], saved);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nabp_map_scheduler.md
Name: nabp_map_scheduler

Overview:
Sequences the projection-line mapper over every angle and image partition of one backprojection frame. For each (angle, partition) pair it:
- fetches the per-angle fixed-point accumulator constants from the angle table;
- derives the partition start value;
- drives mp_accu_init / mp_accu_base to the mapper;
- issues sh_kick, then waits for the shifter/mapper pass to complete.

It sits between state control (frame start/abort) and the mapper/shifter pair.

Parameters:
- kAngleLength, 9, angle index width.
- kNoOfAngles, 180, angles per frame; legal range 1..2^kAngleLength.
- kPartWidth, 3, partition index width.
- kNoOfParts, 4, partitions per angle; legal range 1..2^kPartWidth.
- kAccuInitWidth, 24, signed fixed-point width of mp_accu_init (tMapAccuInit).
- kAccuBaseWidth, 20, signed fixed-point width of mp_accu_base and of the partition step (tMapAccuBase).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sc_start  in  1  one-cycle frame start pulse
- sc_abort  in  1  synchronous abort of the current frame
- sc_busy  out  1  high from accepted start until the DONE cycle completes
- sc_done  out  1  one-cycle pulse after the last pass finishes
- lut_req  out  1  angle table read strobe
- lut_angle  out  kAngleLength  angle table address
- lut_init  in  kAccuInitWidth  accumulator init for partition 0
- lut_base  in  kAccuBaseWidth  accumulator increment per shift
- lut_step  in  kAccuBaseWidth  init offset between partitions
- mp_accu_init  out  kAccuInitWidth  registered init to mapper
- mp_accu_base  out  kAccuBaseWidth  registered base to mapper
- sh_kick  out  1  pass start request to shifter/mapper
- sh_ack  in  1  mapper has entered mapping state
- sh_done  in  1  one-cycle pulse at the end of a pass
- cur_angle  out  kAngleLength  angle of the current pass
- cur_part  out  kPartWidth  partition of the current pass

Behaviour:
- Reset values: all outputs 0; state IDLE; angle and partition counters 0. Reset is asynchronous; deassertion takes effect on the next clk.
- Angle table timing: fixed one-cycle read latency. lut_init, lut_base and lut_step are valid in the cycle after lut_req and are sampled only in that cycle.
- IDLE: sc_start=1 moves to FETCH, clears both counters, and sets sc_busy on the next edge. sc_abort has no effect in IDLE.
- FETCH (1 cycle): lut_req=1 and lut_angle=angle counter. Next state is LOAD.
- LOAD (1 cycle):
  - register mp_accu_base <= lut_base and mp_accu_init <= lut_init;
  - hold lut_step in an internal register step_r;
  - next state is KICK.
- KICK: sh_kick=1, held until sh_ack is sampled high. On sh_ack, move to RUN, with sh_kick low from the next cycle.
- RUN: wait for sh_done. On sh_done:
  - if part < kNoOfParts-1: part += 1, mp_accu_init <= mp_accu_init + sign-extended step_r, go to KICK. No refetch.
  - else if angle < kNoOfAngles-1: angle += 1, part <= 0, go to FETCH.
  - else go to DONE.
- DONE (1 cycle): sc_done=1, then IDLE. sc_busy falls at the DONE to IDLE edge.
- Minimum inter-pass gap:
  - same angle: 1 cycle (RUN to KICK);
  - angle change: 3 cycles (RUN to FETCH to LOAD to KICK).
- mp_accu_init and mp_accu_base stay stable from LOAD, or from the partition update, until the next update. They never change in KICK or RUN.
- Arithmetic: two's-complement, wrapping, no saturation. The table guarantees no overflow.
- sh_done outside RUN is ignored. This includes sh_done coinciding with sh_ack in KICK.
- sc_start while busy is ignored.
- sc_abort in any non-IDLE state:
  - next state IDLE;
  - sh_kick and lut_req deassert on the next cycle;
  - sc_busy deasserts on the next cycle;
  - counters are cleared;
  - no sc_done pulse.
- sc_abort and sc_start in the same cycle from IDLE: start wins.
- sc_abort and sh_done in the same cycle: abort wins.
- Degenerate sizes: kNoOfParts=1 never takes the partition-step path. kNoOfAngles=1 gives exactly one FETCH.
- cur_angle and cur_part equal the counters and are valid throughout KICK and RUN.

Decomposition:
- Shared package (nabp_pkg): state encoding (IDLE, FETCH, LOAD, KICK, RUN, DONE), with widths derived from conf kAngleLength / tMapAccuInit / tMapAccuBase.
- One natural sub-module, nabp_map_sched_counter: the nested angle/partition counter with last_part and last_angle flags, advanced by a single step strobe.
- Remaining logic (FSM and init accumulator) stays in the top module. Target size is about 200 lines.

Test Plan:
1. kNoOfAngles=2, kNoOfParts=1, table angle0 {init=0x000100, base=0x00080}, angle1 {init=0x000200, base=0x00100}, mapper model acks 2 cycles after kick and done 10 cycles after ack -> exactly 2 kicks; mp_accu_init is 0x000100 then 0x000200; sc_done pulses once; sc_busy low afterwards.
2. kNoOfParts=4, init=0x001000, step=0xFFF00 (-256) -> mp_accu_init sequence 0x001000, 0x000F00, 0x000E00, 0x000D00; lut_req pulses once per angle.
3. Abort during RUN of angle 5 partition 2 -> IDLE next cycle; sh_kick=0; no sc_done; a following sc_start refetches angle 0.
4. sh_done injected during KICK, and sc_start pulsed while busy -> both ignored; pass count and sc_done timing unchanged.
5. reset_n asserted mid-frame asynchronously (between clk edges) -> all outputs 0 immediately; after release, IDLE with no spurious sh_kick.
6. Full 180-angle frame with a 1-cycle ack mapper -> 180×kNoOfParts kicks; cur_angle monotonic 0..179; sc_done once.
